// File: rtl/fsm_pkg.sv
// fsm_pkg
// Shared constants and types for the sequence-detector slice.
//   - legal ranges for the pattern length and the match-counter width
//   - match_mode_e: how the detector restarts after a hit
//   - reset value of the latched match mode
//   - fill_width(): bits needed for a fill counter of range 0..pat_w-1
package fsm_pkg;

  localparam int PAT_W_MIN = 2;
  localparam int PAT_W_MAX = 16;
  localparam int CNT_W_MIN = 1;
  localparam int CNT_W_MAX = 32;

  typedef enum logic {
    MATCH_DISJOINT = 1'b0,
    MATCH_OVERLAP  = 1'b1
  } match_mode_e;

  localparam match_mode_e OVERLAP_RST = MATCH_OVERLAP;

  function automatic int fill_width(input int pat_w);
    return $clog2(pat_w);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Saturating up-counter with a synchronous clear.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset, clears the count
//   clr  - clear the count; wins over a same-cycle inc
//   inc  - add one unless already at all-ones
//   q    - current count
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/seq_detect_param.sv
// seq_detect_param
// Serial pattern detector with a programmable PAT_W-bit pattern, selectable
// overlapping / non-overlapping matching and a saturating match counter.
// Ports:
//   clk          - clock, rising edge
//   rst          - synchronous active-high reset
//   x, x_valid   - serial data bit and its qualifier
//   cfg_pattern  - target pattern, MSB is the first bit received
//   cfg_load     - latch cfg_pattern/cfg_overlap and restart the history
//   cfg_overlap  - 1 = overlapping matches, 0 = non-overlapping
//   cnt_clr      - clear the match counter
//   z            - Mealy match flag for the current bit
//   z_q          - z delayed by one cycle
//   match_cnt    - saturating number of matches
//   armed        - history is full, the next valid bit can complete a match
module seq_detect_param
  import fsm_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             x_valid,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_load,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             z,
  output logic             z_q,
  output logic [CNT_W-1:0] match_cnt,
  output logic             armed
);

  if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
    $error("seq_detect_param: PAT_W out of range");
  end
  if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
    $error("seq_detect_param: CNT_W out of range");
  end

  localparam int              FILL_W   = fill_width(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  pat_q,  pat_d;
  match_mode_e       mode_q, mode_d;
  logic [PAT_W-2:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              z_d;

  // Candidate window: the stored history followed by the incoming bit.
  logic [PAT_W-1:0]  window;
  assign window = {hist_q, x};

  always_comb begin
    pat_d  = pat_q;
    mode_d = mode_q;
    hist_d = hist_q;
    fill_d = fill_q;
    z_d    = 1'b0;
    if (cfg_load) begin
      // A load restarts detection; any same-cycle bit is dropped.
      pat_d  = cfg_pattern;
      mode_d = match_mode_e'(cfg_overlap);
      fill_d = '0;
    end else if (x_valid) begin
      z_d    = (fill_q == FILL_MAX) && (window == pat_q);
      hist_d = window[PAT_W-2:0];
      if (z_d) begin
        // Overlapping keeps fill saturated so the tail can start the next hit.
        if (mode_q == MATCH_DISJOINT) begin
          fill_d = '0;
        end
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
    if (rst) begin
      z_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q  <= '0;
      mode_q <= OVERLAP_RST;
      hist_q <= '0;
      fill_q <= '0;
      z_q    <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      mode_q <= mode_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      z_q    <= z_d;
    end
  end

  assign z     = z_d;
  assign armed = (fill_q == FILL_MAX);

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (z_d),
    .q   (match_cnt)
  );

endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param
// Drives two detectors (8-bit and 2-bit match counters) with the same
// stimulus and compares them against a queue-based reference model: the
// model keeps the valid bits seen since the last restart and declares a
// match when the newest PAT_W of them spell the latched pattern.
module tb_seq_detect_param;

  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          x = 1'b0;
  logic          x_valid = 1'b0;
  logic [PW-1:0] cfg_pattern = '0;
  logic          cfg_load = 1'b0;
  logic          cfg_overlap = 1'b0;
  logic          cnt_clr = 1'b0;

  logic          z, z_q, armed;
  logic [7:0]    match_cnt;
  logic          z2, z_q2, armed2;
  logic [1:0]    match_cnt2;

  int compared = 0;
  int mismatched = 0;

  // Reference model state
  bit            bits[$];
  logic [PW-1:0] m_pat = '0;
  bit            m_ovl = 1'b1;
  int            m_cnt8 = 0;
  int            m_cnt2 = 0;

  always #5 clk = ~clk;

  seq_detect_param #(.PAT_W(PW), .CNT_W(8)) dut (
    .clk (clk), .rst (rst), .x (x), .x_valid (x_valid),
    .cfg_pattern (cfg_pattern), .cfg_load (cfg_load),
    .cfg_overlap (cfg_overlap), .cnt_clr (cnt_clr),
    .z (z), .z_q (z_q), .match_cnt (match_cnt), .armed (armed)
  );

  seq_detect_param #(.PAT_W(PW), .CNT_W(2)) dut_c2 (
    .clk (clk), .rst (rst), .x (x), .x_valid (x_valid),
    .cfg_pattern (cfg_pattern), .cfg_load (cfg_load),
    .cfg_overlap (cfg_overlap), .cnt_clr (cnt_clr),
    .z (z2), .z_q (z_q2), .match_cnt (match_cnt2), .armed (armed2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      $error("[TB] %s disagrees with reference", tag);
    end
  endtask

  // One clock cycle: drive at negedge, check z before the edge, check the
  // registered outputs just after it.
  task automatic applyStimulus(input bit r, input bit xi, input bit xv,
                               input logic [PW-1:0] pat, input bit ld,
                               input bit ov, input bit cl);
    logic [PW-1:0] w;
    bit            m;
    @(negedge clk);
    rst = r; x = xi; x_valid = xv; cfg_pattern = pat;
    cfg_load = ld; cfg_overlap = ov; cnt_clr = cl;
    m = 1'b0;
    w = '0;
    if (!r && !ld && xv) begin
      bits.push_back(xi);
      if (bits.size() > PW) void'(bits.pop_front());
      if (bits.size() == PW) begin
        for (int i = 0; i < PW; i++) w[PW-1-i] = bits[i];
        m = (w == m_pat);
      end
      if (m && !m_ovl) bits.delete();
    end
    #1;
    checkOutput("z", {31'd0, z}, {31'd0, m});
    checkOutput("z_c2", {31'd0, z2}, {31'd0, m});
    if (r) begin
      bits.delete();
      m_pat = '0; m_ovl = 1'b1; m_cnt8 = 0; m_cnt2 = 0;
    end else begin
      if (ld) begin
        m_pat = pat; m_ovl = ov; bits.delete();
      end
      if (cl) begin
        m_cnt8 = 0; m_cnt2 = 0;
      end else if (m) begin
        m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
        m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
      end
    end
    @(posedge clk);
    #1;
    checkOutput("z_q", {31'd0, z_q}, {31'd0, m});
    checkOutput("z_q_c2", {31'd0, z_q2}, {31'd0, m});
    checkOutput("match_cnt", {24'd0, match_cnt}, m_cnt8);
    checkOutput("match_cnt_c2", {30'd0, match_cnt2}, m_cnt2);
    checkOutput("armed", {31'd0, armed}, {31'd0, bits.size() >= PW - 1});
    checkOutput("armed_c2", {31'd0, armed2}, {31'd0, bits.size() >= PW - 1});
  endtask

  task automatic resetCycle();
    applyStimulus(1'b1, 1'($urandom), 1'($urandom), PW'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic loadCfg(input logic [PW-1:0] p, input bit ov);
    applyStimulus(1'b0, 1'($urandom), 1'($urandom), p, 1'b1, ov, 1'b0);
  endtask

  task automatic sendBit(input bit b);
    applyStimulus(1'b0, b, 1'b1, PW'($urandom), 1'b0, 1'($urandom), 1'b0);
  endtask

  task automatic gapCycle();
    applyStimulus(1'b0, 1'($urandom), 1'b0, PW'($urandom), 1'b0, 1'($urandom), 1'b0);
  endtask

  task automatic clearCnt();
    applyStimulus(1'b0, 1'($urandom), 1'b0, PW'($urandom), 1'b0, 1'($urandom), 1'b1);
  endtask

  task automatic streamBits(input logic [15:0] seq, input int len);
    for (int i = len - 1; i >= 0; i--) sendBit(seq[i]);
  endtask

  initial begin
    $display("[TB] start");

    resetCycle();
    resetCycle();
    checkOutput("rst_cnt", {24'd0, match_cnt}, 32'd0);
    checkOutput("rst_armed", {31'd0, armed}, 32'd0);

    // Overlapping 1011 over 1011011: hits on bits 4 and 7
    loadCfg(4'b1011, 1'b1);
    streamBits(16'b1011011, 7);
    checkOutput("ovl_1011_cnt", {24'd0, match_cnt}, 32'd2);

    // Non-overlapping: only bit 4
    clearCnt();
    loadCfg(4'b1011, 1'b0);
    streamBits(16'b1011011, 7);
    checkOutput("disj_1011_cnt", {24'd0, match_cnt}, 32'd1);

    // 1111 over seven ones
    clearCnt();
    loadCfg(4'b1111, 1'b1);
    streamBits(16'b1111111, 7);
    checkOutput("ovl_1111_cnt", {24'd0, match_cnt}, 32'd4);
    checkOutput("ovl_1111_cnt_c2", {30'd0, match_cnt2}, 32'd3);
    clearCnt();
    loadCfg(4'b1111, 1'b0);
    streamBits(16'b1111111, 7);
    checkOutput("disj_1111_cnt", {24'd0, match_cnt}, 32'd1);

    // Gaps between valid bits
    clearCnt();
    loadCfg(4'b1011, 1'b1);
    sendBit(1'b1); gapCycle(); gapCycle();
    sendBit(1'b0); gapCycle();
    sendBit(1'b1); gapCycle(); gapCycle();
    sendBit(1'b1);
    checkOutput("gap_zq_high", {31'd0, z_q}, 32'd1);
    gapCycle();
    checkOutput("gap_zq_low", {31'd0, z_q}, 32'd0);
    checkOutput("gap_cnt", {24'd0, match_cnt}, 32'd1);

    // Reset mid-stream
    clearCnt();
    loadCfg(4'b1011, 1'b1);
    sendBit(1'b1); sendBit(1'b0); sendBit(1'b1);
    resetCycle();
    sendBit(1'b1);
    checkOutput("midrst_cnt", {24'd0, match_cnt}, 32'd0);

    // cfg_load coinciding with the completing bit
    loadCfg(4'b1011, 1'b1);
    streamBits(16'b1011, 4);
    sendBit(1'b0); sendBit(1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'b1011, 1'b1, 1'b1, 1'b0);
    checkOutput("load_cnt", {24'd0, match_cnt}, 32'd1);
    checkOutput("load_armed", {31'd0, armed}, 32'd0);

    // Saturation of the 2-bit counter, then clear against a match
    clearCnt();
    loadCfg(4'b1111, 1'b1);
    streamBits(16'b11111111, 8);
    checkOutput("sat_cnt_c2", {30'd0, match_cnt2}, 32'd3);
    checkOutput("sat_cnt", {24'd0, match_cnt}, 32'd5);
    applyStimulus(1'b0, 1'b1, 1'b1, PW'($urandom), 1'b0, 1'b0, 1'b1);
    checkOutput("clr_vs_match_zq", {31'd0, z_q}, 32'd1);
    checkOutput("clr_vs_match_cnt_c2", {30'd0, match_cnt2}, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(0, 99) < 2, 1'($urandom),
                    $urandom_range(0, 99) < 75, PW'($urandom),
                    $urandom_range(0, 99) < 5, 1'($urandom),
                    $urandom_range(0, 99) < 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
